// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader
// Streams one frame of RGB565 pixels out of a double-buffered SRAM into a
// small prefetch FIFO for the VGA consumer. The reader displays the frame
// that is NOT currently being written upstream.
//
// Optional feature: define FBR_UNDERRUN_CNT_EN to add the underrun_cnt
// output, a saturating count of pops requested while the FIFO was empty.
// With the macro undefined the port and its logic do not exist.

module frame_buffer_reader #(
    parameter int          DEPTH       = 16,
    parameter int          FRAME_WORDS = 307200,
    parameter logic [19:0] ODD_BASE    = 20'h4B000
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        frame_sync,
    input  logic        even_frame,
    input  logic        bus_gnt,
    output logic        bus_req,
    output logic [19:0] SRAM_ADDRESS,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    input  logic [15:0] Data_from_SRAM,
    input  logic        pix_rd,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        frame_done
`ifdef FBR_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    // FIFO pointer width, FIFO count width (holds 0..DEPTH), word counter width
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(FRAME_WORDS + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [WW-1:0] LAST_WORD  = WW'(FRAME_WORDS - 1);
    localparam logic [19:0]   EVEN_BASE  = 20'h00000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Read address generation
    logic [19:0]   r_addr;       // next address to issue
    logic [19:0]   r_last_addr;  // last address actually issued (held on the bus)
    logic [WW-1:0] r_wcnt;       // words issued in the current frame
    logic          r_frame_done;

    // Two-stage pipeline of "a read is in flight" flags matching SRAM latency
    logic [1:0]    r_vld;

    // Prefetch FIFO
    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_occ;
    logic          w_room;
    logic          w_bus_req;
    logic          w_issue;
    logic          w_last;
    logic          w_push;
    logic          w_pop;
    logic [19:0]   w_base;

    // The frame being displayed is the one not being written: when the
    // writer is on the even frame we read the odd one, and vice versa.
    assign w_base = even_frame ? ODD_BASE : EVEN_BASE;

    // Reserve FIFO space for reads still in flight so a push can never
    // land on a full FIFO.
    assign w_occ  = r_count
                  + {{(CW-1){1'b0}}, r_vld[0]}
                  + {{(CW-1){1'b0}}, r_vld[1]};
    assign w_room = (w_occ < FULL_COUNT);

    // Data arrives two cycles after issue; r_vld[1] marks that cycle.
    assign w_push = r_vld[1];
    assign w_pop  = pix_rd && (r_count != '0);

    // Next-state and bus request/issue decode; frame_sync overrides everything
    always_comb begin
        w_state_next = r_state;
        w_bus_req    = 1'b0;
        w_issue      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_IDLE;
            end
            S_FETCH: begin
                w_bus_req = w_room && !frame_sync;
                w_issue   = w_bus_req && bus_gnt;
                w_last    = w_issue && (r_wcnt == LAST_WORD);
                if (w_last) begin
                    w_state_next = S_DONE;
                end else if (!w_room) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_room) begin
                    w_state_next = S_FETCH;
                end
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (frame_sync) begin
            w_state_next = S_FETCH;
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Address, word counter and end-of-frame pulse. The address stops on
    // the final word so it never runs past the end of the frame.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            r_addr       <= 20'h00000;
            r_last_addr  <= 20'h00000;
            r_wcnt       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (frame_sync) begin
                r_addr <= w_base;
                r_wcnt <= '0;
            end else if (w_issue) begin
                r_last_addr <= r_addr;
                r_wcnt      <= r_wcnt + WW'(1);
                if (!w_last) begin
                    r_addr <= r_addr + 20'h00001;
                end
            end
        end
    end

    // In-flight tracker; clearing it drops data from reads issued before a
    // reset or restart.
    always_ff @(posedge Clk) begin
        if (!Reset_N || frame_sync) begin
            r_vld <= 2'b00;
        end else begin
            r_vld <= {r_vld[0], w_issue};
        end
    end

    // FIFO pointers and occupancy; a restart empties the FIFO.
    always_ff @(posedge Clk) begin
        if (!Reset_N || frame_sync) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write; contents need no reset since the count gates them.
    always_ff @(posedge Clk) begin
        if (Reset_N && !frame_sync && w_push) begin
            r_mem[r_wr_ptr] <= Data_from_SRAM;
        end
    end

    // Space reservation makes an overflowing push impossible.
    a_no_overflow: assert property (
        @(posedge Clk) disable iff (!Reset_N || frame_sync)
        !(w_push && !w_pop && (r_count == FULL_COUNT))
    );

`ifdef FBR_UNDERRUN_CNT_EN
    logic [15:0] r_underrun;

    // Count pops the consumer attempted while the FIFO was empty
    always_ff @(posedge Clk) begin
        if (!Reset_N || frame_sync) begin
            r_underrun <= 16'h0000;
        end else if (pix_rd && (r_count == '0) && (r_underrun != 16'hFFFF)) begin
            r_underrun <= r_underrun + 16'h0001;
        end
    end

    assign underrun_cnt = r_underrun;
`else
    // Underrun counting not built in this configuration.
`endif

    assign bus_req      = w_bus_req;
    assign SRAM_OE_N    = !w_issue;
    assign SRAM_ADDRESS = w_issue ? r_addr : r_last_addr;
    assign SRAM_WE_N    = 1'b1;
    assign pix_valid    = (r_count != '0);
    assign pix_data     = pix_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign frame_done   = r_frame_done;

endmodule
